// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receiver and the transmitter:
// FSM state encodings, channel constants and default frame geometry.
package i2s_pkg;

  typedef enum logic {
    ST_WAIT    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  localparam logic LEFT_CHANNEL  = 1'b0;
  localparam logic RIGHT_CHANNEL = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DIVISOR       = 512;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with an optional
// rising-edge strobe taken from one extra register after the last stage.
// SYNC_STAGES must be at least 2.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_Async};
  end

  assign o_Sync = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      // Remember the previous synced level to detect a low-to-high step.
      always_ff @(posedge i_Clk) begin
        if (i_Rst) prev_q <= 1'b0;
        else       prev_q <= sync_q[SYNC_STAGES-1];
      end

      assign o_Rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    end else begin : g_noedge
      assign o_Rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples SCLK/LRCLK/SDOUT, deserialises MSB-first
// left/right words and strobes o_Valid once per completed stereo frame.
// Optional word-length checking with resync is enabled by defining
// I2S_RX_FRAME_CHECK_EN; otherwise o_Frame_Err is tied low.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int NUM_OF_AMPLITUDE_BITS = DEFAULT_WIDTH,
  parameter int SYNC_STAGES           = 2
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_SCLK,
  input  logic                             i_LRCLK,
  input  logic                             i_SDOUT,
  output logic [NUM_OF_AMPLITUDE_BITS-1:0] o_Left,
  output logic [NUM_OF_AMPLITUDE_BITS-1:0] o_Right,
  output logic                             o_Valid,
  output logic                             o_Frame_Err
);

  localparam int W  = NUM_OF_AMPLITUDE_BITS;
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

  logic sclkRise, lrSync, sdSync;
  logic sclkSync_unused, lrRise_unused, sdRise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SCLK),
    .o_Sync(sclkSync_unused), .o_Rise(sclkRise)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrclk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_LRCLK),
    .o_Sync(lrSync), .o_Rise(lrRise_unused)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdout (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SDOUT),
    .o_Sync(sdSync), .o_Rise(sdRise_unused)
  );

  state_t          state_q, state_d;
  logic [W-1:0]    shiftReg_q, shiftReg_d, shiftIn, justified;
  logic [CW-1:0]   bitCnt_q, bitCnt_d, bitCntInc, padShift;
  logic            lrLast_q, lrLast_d;
  logic            wordDone_q, wordDone_d;
  logic            wordLr_q, wordLr_d;
  logic [W-1:0]    word_q, word_d;
  logic [W-1:0]    leftHold_q, left_q, right_q;
  logic            valid_q;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic            lenErr, lenErr_q, frameErr_q;
`endif

  // Shift/count/justify helpers for the bit captured on this sclk_rise.
  always_comb begin
    shiftIn   = (bitCnt_q < CNT_FULL) ? {shiftReg_q[W-2:0], sdSync} : shiftReg_q;
    bitCntInc = (bitCnt_q == CNT_SAT) ? bitCnt_q : bitCnt_q + CW'(1);
    padShift  = (bitCntInc < CNT_FULL) ? (CNT_FULL - bitCntInc) : '0;
    justified = shiftIn << padShift;
`ifdef I2S_RX_FRAME_CHECK_EN
    lenErr    = sclkRise && (state_q == ST_CAPTURE) && (lrSync != lrLast_q) &&
                (bitCntInc != CNT_FULL);
`endif
  end

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_WAIT;
    else       state_q <= state_d;
  end

  // FSM next state: lock on at the first word-select change; a bad word length drops back to discard mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (sclkRise && (lrSync != lrLast_q)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
`ifdef I2S_RX_FRAME_CHECK_EN
        if (lenErr) state_d = ST_WAIT;
`endif
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // FSM datapath outputs: shift bits in, and hand a finished word to the output stage at each boundary.
  always_comb begin
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    lrLast_d   = lrLast_q;
    wordDone_d = 1'b0;
    wordLr_d   = wordLr_q;
    word_d     = word_q;
    if (sclkRise) begin
      if (lrSync != lrLast_q) begin
        lrLast_d   = lrSync;
        bitCnt_d   = '0;
        shiftReg_d = '0;
        if (state_q == ST_CAPTURE) begin
          wordDone_d = 1'b1;
          wordLr_d   = lrLast_q;
          word_d     = justified;
        end
      end else if (state_q == ST_CAPTURE) begin
        shiftReg_d = shiftIn;
        bitCnt_d   = bitCntInc;
      end
    end
  end

  // Deserialiser registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      lrLast_q   <= 1'b0;
      wordDone_q <= 1'b0;
      wordLr_q   <= 1'b0;
      word_q     <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      lrLast_q   <= lrLast_d;
      wordDone_q <= wordDone_d;
      wordLr_q   <= wordLr_d;
      word_q     <= word_d;
    end
  end

  // Output stage: park left words, publish the pair when a right word finishes.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      leftHold_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (wordDone_q) begin
        if (wordLr_q == LEFT_CHANNEL) begin
          leftHold_q <= word_q;
        end else begin
          left_q  <= leftHold_q;
          right_q <= word_q;
          valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  // Delay the length error so it lines up with the word's store/valid cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lenErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      lenErr_q   <= lenErr;
      frameErr_q <= lenErr_q;
    end
  end
  assign o_Frame_Err = frameErr_q;
`else
  assign o_Frame_Err = 1'b0;
`endif

  assign o_Left  = left_q;
  assign o_Right = right_q;
  assign o_Valid = valid_q;

endmodule
